pwm_multichannel: RTL and testbench
===================================

PWM_MULTICHANNEL -- requirements
Module: pwm_multichannel

Interface
REQ-001 SHALL have parameter CHANNELS, default 16, number of PWM channels (range 1..32).
REQ-002 SHALL have parameter WIDTH, default 8, duty and period counter width in bits (range 2..16).
REQ-003 SHALL have parameter PRESCALE_W, default 8, prescaler divisor width in bits.
REQ-004 SHALL have one clock and a synchronous, active-high reset. All ports are listed below, clock and reset first.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 wr_en  input  1  duty write strobe; one write per asserted cycle.
REQ-008 wr_chan  input  $clog2(CHANNELS) (min 1)  channel index for the write.
REQ-009 wr_duty  input  WIDTH  duty value for the write.
REQ-010 sync_mode  input  1  1 = duty takes effect at the period boundary; 0 = immediate.
REQ-011 out_en  input  CHANNELS  per-channel output enable.
REQ-012 pwm_en  input  CHANNELS  per-channel PWM enable; 0 = static high when out_en is set.
REQ-013 div  input  PRESCALE_W  prescaler; the counter advances once every div+1 clk cycles.
REQ-014 out  output  CHANNELS  registered channel outputs.
REQ-015 period_start  output  1  registered one-cycle pulse marking counter value 0.

Function
REQ-016 Prescaler:
- pre_cnt counts 0..div.
- tick is asserted in the cycle pre_cnt==div; pre_cnt returns to 0 on that cycle.
- div==0 gives tick every cycle.
- A div change mid-count SHALL take effect by comparison only; if pre_cnt>div, pre_cnt wraps to 0 on the next cycle.
REQ-017 Period counter:
- cnt (WIDTH bits) increments on tick and wraps from 2^WIDTH-1 to 0.
- Period = 2^WIDTH * (div+1) clk cycles.
REQ-018 Each channel SHALL hold a pending duty register and an active duty register, each WIDTH bits.
REQ-019 A write with wr_en=1 and wr_chan<CHANNELS SHALL load pending[wr_chan] at that edge. A write with wr_chan>=CHANNELS SHALL be ignored with no state change.
REQ-020 Boundary event is tick && cnt==2^WIDTH-1. On a boundary event, every active[i] SHALL load pending[i] as held before that edge; a write in the same cycle lands in pending and applies at the following boundary.
REQ-021 With sync_mode=0, an accepted write SHALL also load active[wr_chan] at the same edge.
REQ-022 Level function:
- level[i] = 1 if active[i] == 2^WIDTH-1 (full-on).
- Otherwise level[i] = (cnt < active[i]).
- active[i]==0 gives constant low.
REQ-023 Output function, registered:
- out[i] <= out_en[i] ? (pwm_en[i] ? level[i] : 1) : 0.
- out reflects cnt and active as they stand at the preceding edge (1-cycle latency).
REQ-024 period_start SHALL be registered high for exactly one cycle, the cycle after cnt first becomes 0. Its timing SHALL align with out showing the cnt==0 level.
REQ-025 out_en, pwm_en and div SHALL be sampled every cycle without buffering. Changes appear on out one cycle later.
REQ-026 Simultaneous writes to different channels are impossible (single port). Back-to-back writes to the same channel SHALL keep the last value.

Reset
REQ-027 While rst=1, the following SHALL clear to 0 at the next edge:
- pre_cnt, cnt
- all pending and active duty registers
- out, period_start
REQ-028 Reset asserted mid-period SHALL discard the period in progress. After release, cnt restarts at 0 and the first period_start follows 2^WIDTH*(div+1) cycles later.
REQ-029 Writes presented while rst=1 SHALL be ignored.

Verification (CHANNELS=16, WIDTH=8 unless stated)
REQ-030 Reset: rst=1 for 2 cycles with wr_en=1 -> out=0x0000, period_start=0. After release, with out_en=0xFFFF, pwm_en=0x0000 -> out=0xFFFF one cycle later. With pwm_en=0xFFFF and no writes -> out stays 0x0000.
REQ-031 Duty and full-on: div=0, sync_mode=1, write ch3=0x80 -> no change before the next period_start. After it, out[3] is high 128 and low 128 of every 256 cycles. A write of 0xFF makes out[3] constant 1; a write of 0x00 makes it constant 0.
REQ-032 Prescaler: div=3, ch0=0x40 -> period 1024 cycles, out[0] high 256 cycles per period, period_start spaced exactly 1024 cycles apart.
REQ-033 Sync vs immediate: mid-period write ch5=0x10 with sync_mode=1 -> old duty persists until the boundary. With sync_mode=0 -> out[5] reflects the new duty within 2 cycles. A write on the boundary cycle with sync_mode=1 -> applies one period later.
REQ-034 Edge cases: write with wr_chan out of range (CHANNELS=12, wr_chan=13) -> no register changes. Reset at cnt=0x7F -> cnt restarts at 0, all outputs 0.

Source files
------------

// File: rtl/pwm_multichannel_if.sv
// Control and output bundle for pwm_multichannel: duty write port, per-channel
// enables, prescaler divisor, and the registered PWM outputs.
interface pwm_multichannel_if #(
  parameter int CHANNELS   = 16,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) ();
  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                  wr_en;
  logic [CHAN_W-1:0]     wr_chan;
  logic [WIDTH-1:0]      wr_duty;
  logic                  sync_mode;
  logic [CHANNELS-1:0]   out_en;
  logic [CHANNELS-1:0]   pwm_en;
  logic [PRESCALE_W-1:0] div;
  logic [CHANNELS-1:0]   out;
  logic                  period_start;

  modport master (
    output wr_en, wr_chan, wr_duty, sync_mode, out_en, pwm_en, div,
    input  out, period_start
  );

  modport slave (
    input  wr_en, wr_chan, wr_duty, sync_mode, out_en, pwm_en, div,
    output out, period_start
  );
endinterface

// File: rtl/pwm_multichannel.sv
// Multichannel PWM generator: shared prescaled period counter, per-channel
// pending/active duty registers with boundary or immediate update.
module pwm_multichannel #(
  parameter int CHANNELS   = 16,
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  pwm_multichannel_if.slave  bus
);
  localparam int              CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [PRESCALE_W-1:0] r_pre_cnt;
  logic [WIDTH-1:0]      r_cnt;
  logic [WIDTH-1:0]      r_pending [CHANNELS];
  logic [WIDTH-1:0]      r_active  [CHANNELS];
  logic                  r_wrap_p0;
  logic [CHANNELS-1:0]   r_out_p1;
  logic                  r_period_start_p1;

  logic                  w_tick;
  logic                  w_boundary;
  logic                  w_wr_ok;
  logic [CHANNELS-1:0]   w_level;

  assign w_tick     = (r_pre_cnt == bus.div);
  assign w_boundary = w_tick && (r_cnt == CNT_MAX);
  assign w_wr_ok    = bus.wr_en && (32'(bus.wr_chan) < CHANNELS);

  always_comb begin
    w_level = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_level[i] = (r_active[i] == CNT_MAX) || (r_cnt < r_active[i]);
    end
  end

  // Stage p0: prescaler, period counter; r_wrap_p0 remembers a counter wrap,
  // so a reset-forced zero never produces a period_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt <= '0;
      r_cnt     <= '0;
      r_wrap_p0 <= 1'b0;
    end else begin
      r_pre_cnt <= (r_pre_cnt >= bus.div) ? '0 : r_pre_cnt + 1'b1;
      if (w_tick) r_cnt <= r_cnt + 1'b1;
      r_wrap_p0 <= w_boundary;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pending[i] <= '0;
        r_active[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_boundary) r_active[i] <= r_pending[i];
        if (w_wr_ok && (bus.wr_chan == CHAN_W'(i))) begin
          r_pending[i] <= bus.wr_duty;
          if (!bus.sync_mode) r_active[i] <= bus.wr_duty;
        end
      end
    end
  end

  // Stage p1: registered outputs, aligned with the cnt value of stage p0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_p1          <= '0;
      r_period_start_p1 <= 1'b0;
    end else begin
      r_out_p1          <= bus.out_en & (~bus.pwm_en | w_level);
      r_period_start_p1 <= r_wrap_p0;
    end
  end

  assign bus.out          = r_out_p1;
  assign bus.period_start = r_period_start_p1;
endmodule

// File: tb/tb_pwm_multichannel.sv
// Scoreboarded bench for pwm_multichannel: a behavioural model predicts every
// registered output; directed windows measure duty, period and reset behaviour.
module tb_pwm_multichannel;
  localparam int CH  = 16;
  localparam int W   = 8;
  localparam int PW  = 8;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic rst12;
  always #5 clk = ~clk;

  pwm_multichannel_if #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) bus ();
  pwm_multichannel #(.CHANNELS(CH), .WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  pwm_multichannel_if #(.CHANNELS(12), .WIDTH(W), .PRESCALE_W(PW)) bus12 ();
  pwm_multichannel #(.CHANNELS(12), .WIDTH(W), .PRESCALE_W(PW)) dut12 (
    .clk(clk), .rst(rst12), .bus(bus12)
  );

  typedef struct {
    logic [CH-1:0] out;
    logic          ps;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int m_pre, m_cnt, m_prev_cnt;
  int m_pend [CH];
  int m_act  [CH];

  logic [CH-1:0] obs_out;
  logic          obs_ps;
  int            meas_ch, meas_hi, meas_ps;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predict the outputs of the coming edge, advance the model, then compare.
  task automatic cycle();
    exp_t e;
    bit   tick, bnd;
    int   wc;
    if (rst) begin
      e.out = '0;
      e.ps  = 1'b0;
    end else begin
      e.ps = (m_cnt == 0) && (m_prev_cnt == MAXV);
      for (int i = 0; i < CH; i++) begin
        if (!bus.out_en[i])        e.out[i] = 1'b0;
        else if (!bus.pwm_en[i])   e.out[i] = 1'b1;
        else if (m_act[i] == MAXV) e.out[i] = 1'b1;
        else                       e.out[i] = (m_cnt < m_act[i]);
      end
    end
    sb_q.push_back(e);

    if (rst) begin
      m_pre = 0; m_cnt = 0; m_prev_cnt = 0;
      for (int i = 0; i < CH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
    end else begin
      tick       = (m_pre == int'(bus.div));
      m_pre      = (m_pre >= int'(bus.div)) ? 0 : m_pre + 1;
      m_prev_cnt = m_cnt;
      bnd        = tick && (m_cnt == MAXV);
      if (tick) m_cnt = (m_cnt + 1) % (1 << W);
      if (bnd) for (int i = 0; i < CH; i++) m_act[i] = m_pend[i];
      wc = int'(bus.wr_chan);
      if (bus.wr_en && wc < CH) begin
        m_pend[wc] = int'(bus.wr_duty);
        if (!bus.sync_mode) m_act[wc] = int'(bus.wr_duty);
      end
    end

    @(posedge clk);
    #1;
    e       = sb_q.pop_front();
    obs_out = bus.out;
    obs_ps  = bus.period_start;
    chk_eq("out", 32'(obs_out), 32'(e.out));
    chk_eq("period_start", 32'(obs_ps), 32'(e.ps));
    if (obs_out[meas_ch]) meas_hi++;
    if (obs_ps) meas_ps++;
  endtask

  task automatic wr(input int chan, input int duty, input bit sync);
    bus.wr_en     = 1'b1;
    bus.wr_chan   = 4'(chan);
    bus.wr_duty   = 8'(duty);
    bus.sync_mode = sync;
    cycle();
    bus.wr_en     = 1'b0;
  endtask

  task automatic wait_ps(input int budget, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!obs_ps && n < budget);
    chk_eq("wait_period_start", 32'(obs_ps), 32'd1);
  endtask

  task automatic measure(input int ch, input int n, output int hi, output int ps, output bit last_ps);
    meas_ch = ch;
    meas_hi = 0;
    meas_ps = 0;
    repeat (n) cycle();
    hi      = meas_hi;
    ps      = meas_ps;
    last_ps = obs_ps;
  endtask

  task automatic run_to_cnt(input int c);
    int g = 0;
    while (m_cnt != c && g < 5000) begin
      cycle();
      g++;
    end
    chk_eq("run_to_cnt", 32'(m_cnt), 32'(c));
  endtask

  initial begin
    int  n, hi, ps;
    bit  last;
    meas_ch = 0; meas_hi = 0; meas_ps = 0;
    m_pre = 0; m_cnt = 0; m_prev_cnt = 0;
    for (int i = 0; i < CH; i++) begin m_pend[i] = 0; m_act[i] = 0; end

    // Reset with a write pending: the write must be dropped.
    rst = 1'b1; rst12 = 1'b1;
    bus.wr_en = 1'b1; bus.wr_chan = 4'd3; bus.wr_duty = 8'hFF; bus.sync_mode = 1'b0;
    bus.out_en = '0; bus.pwm_en = '0; bus.div = '0;
    bus12.wr_en = 1'b0; bus12.wr_chan = '0; bus12.wr_duty = '0; bus12.sync_mode = 1'b0;
    bus12.out_en = '1; bus12.pwm_en = '1; bus12.div = '0;
    cycle();
    cycle();
    chk_eq("rst_out", 32'(obs_out), 32'h0);
    chk_eq("rst_ps", 32'(obs_ps), 32'h0);

    rst = 1'b0; rst12 = 1'b0;
    bus.wr_en = 1'b0; bus.out_en = '1; bus.pwm_en = '0;
    cycle();
    chk_eq("static_high", 32'(obs_out), 32'hFFFF);
    bus.pwm_en = '1;
    repeat (4) cycle();
    chk_eq("zero_duty_low", 32'(obs_out), 32'h0);

    // 50% duty, sync update at the boundary, then full-on and full-off.
    repeat (20) cycle();
    wr(3, 8'h80, 1'b1);
    repeat (2) cycle();
    chk_eq("sync_hold_ch3", 32'(obs_out[3]), 32'h0);
    wait_ps(600, n);
    measure(3, 256, hi, ps, last);
    chk_eq("duty80_high", 32'(hi), 32'd128);
    chk_eq("duty80_ps_count", 32'(ps), 32'd1);
    chk_eq("duty80_ps_spacing", 32'(last), 32'd1);
    wr(3, 8'hFF, 1'b1);
    wait_ps(600, n);
    measure(3, 256, hi, ps, last);
    chk_eq("dutyFF_high", 32'(hi), 32'd256);
    wr(3, 8'h00, 1'b1);
    wait_ps(600, n);
    measure(3, 256, hi, ps, last);
    chk_eq("duty00_high", 32'(hi), 32'd0);

    // Immediate vs synchronous updates on channel 5.
    wr(5, 8'h40, 1'b0);
    cycle();
    chk_eq("immediate_ch5", 32'(obs_out[5]), 32'h1);
    run_to_cnt(8'h20);
    wr(5, 8'h10, 1'b1);
    repeat (2) cycle();
    chk_eq("sync_old_duty_ch5", 32'(obs_out[5]), 32'h1);
    wait_ps(600, n);
    measure(5, 256, hi, ps, last);
    chk_eq("duty10_high", 32'(hi), 32'd16);
    run_to_cnt(MAXV);
    wr(5, 8'h20, 1'b1);
    wait_ps(8, n);
    measure(5, 256, hi, ps, last);
    chk_eq("boundary_write_old", 32'(hi), 32'd16);
    measure(5, 256, hi, ps, last);
    chk_eq("boundary_write_new", 32'(hi), 32'd32);

    // Prescaler div=3: 1024-cycle period.
    bus.div = 8'd3;
    wr(0, 8'h40, 1'b0);
    wait_ps(3000, n);
    measure(0, 1024, hi, ps, last);
    chk_eq("div3_high", 32'(hi), 32'd256);
    chk_eq("div3_ps_count", 32'(ps), 32'd1);
    chk_eq("div3_ps_at_1024", 32'(last), 32'd1);
    measure(0, 1024, hi, ps, last);
    chk_eq("div3_ps_at_2048", 32'(last), 32'd1);

    // Reset in mid-period; ch1 static high reveals the cleared duty registers.
    bus.div = 8'd0;
    bus.pwm_en = 16'hFFFD;
    run_to_cnt(8'h7F);
    rst = 1'b1;
    cycle();
    chk_eq("mid_rst_out", 32'(obs_out), 32'h0);
    rst = 1'b0;
    cycle();
    chk_eq("post_rst_out", 32'(obs_out), 32'h0002);
    wait_ps(600, n);
    // Released edge 1 shows cnt==0 without a pulse; the next comes one period on.
    chk_eq("post_rst_ps_gap", 32'(n + 1), 32'd257);

    // 12-channel instance: out-of-range channel writes are ignored.
    bus12.wr_en = 1'b1; bus12.wr_duty = 8'hFF; bus12.wr_chan = 4'd13;
    cycle();
    bus12.wr_chan = 4'd12;
    cycle();
    bus12.wr_en = 1'b0;
    repeat (2) cycle();
    chk_eq("oor_write_12ch", 32'(bus12.out), 32'h0);
    bus12.wr_en = 1'b1; bus12.wr_chan = 4'd11;
    cycle();
    bus12.wr_en = 1'b0;
    cycle();
    chk_eq("inrange_write_12ch", 32'(bus12.out), 32'h800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
